// File: rtl/ram_sdp_clr_pkg.sv
// Shared types and constants for the simple-dual-port RAM with clear sequencer.
// Read-during-write mode encodings select how a same-address read sees a write.
package ram_pkg;

  typedef enum logic {
    RAM_IDLE  = 1'b0,
    RAM_CLEAR = 1'b1
  } ram_state_e;

  localparam int RDW_READ_OLD      = 0;
  localparam int RDW_WRITE_THROUGH = 1;

endpackage

// File: rtl/ram_sdp_clr_if.sv
// Bus bundle for ram_sdp_clr: write port, read port and clear control/status.
// master drives requests, slave (the RAM) returns read data, valid and busy.
interface ram_sdp_clr_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 5
);
  logic                  clear_req;
  logic                  busy;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport master (
    output clear_req, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  busy, rd_data, rd_valid
  );

  modport slave (
    input  clear_req, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output busy, rd_data, rd_valid
  );
endinterface

// File: rtl/ram_clear_fsm.sv
// Clear sequencer: sweeps CLEAR_VALUE over every address, one word per cycle.
// Owns busy; while clearing, the user write port is ignored.
module ram_clear_fsm
  import ram_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 4,
  parameter int                    ADDR_WIDTH  = 5,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear_req,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  ram_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      RAM_IDLE: begin
        if (clear_req) state_d = RAM_IDLE == RAM_IDLE ? RAM_CLEAR : RAM_IDLE;
      end
      RAM_CLEAR: begin
        // Address wraps back to zero so the next clear starts at the bottom.
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (clr_addr_q == LAST_ADDR) state_d = RAM_IDLE;
      end
      default: state_d = RAM_IDLE;
    endcase
    busy_d = (state_d == RAM_CLEAR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RAM_CLEAR;
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      busy_q     <= busy_d;
    end
  end

  assign busy = busy_q;

  always_comb begin
    mem_we    = wr_en;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (state_q == RAM_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr_q;
      mem_wdata = CLEAR_VALUE;
    end
  end

endmodule

// File: rtl/ram_sdp_clr.sv
// Simple-dual-port RAM with hardware clear; 1-cycle registered read.
// Reads and writes are dropped while busy; rd_data holds, rd_valid stays low.
module ram_sdp_clr
  import ram_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 4,
  parameter int                    ADDR_WIDTH  = 5,
  parameter int                    RDW_MODE    = RDW_READ_OLD,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  ram_sdp_clr_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  busy;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  rd_en_eff;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  ram_clear_fsm #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .CLEAR_VALUE (CLEAR_VALUE)
  ) u_clear_fsm (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_req (bus.clear_req),
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .wr_data   (bus.wr_data),
    .busy      (busy),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata)
  );

  // No reset on the array so it stays mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign rd_en_eff = bus.rd_en & ~busy;

  always_comb begin
    rd_valid_d = rd_en_eff;
    rd_data_d  = rd_data_q;
    if (rd_en_eff) begin
      rd_data_d = mem[bus.rd_addr];
      if ((RDW_MODE == RDW_WRITE_THROUGH) && mem_we && (mem_waddr == bus.rd_addr))
        rd_data_d = mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.busy     = busy;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Bench for ram_sdp_clr: read-old and write-through instances driven in lockstep
// and compared against an array/countdown reference model.
module tb_ram_sdp_clr;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear_req = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [4:0] rd_addr = '0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] mdl_mem [32];
  int         busy_left = 32;
  logic [3:0] exp_rd0 = '0;
  logic [3:0] exp_rd1 = '0;
  logic       exp_vld = 1'b0;
  logic       exp_busy = 1'b1;

  always #5 clk = ~clk;

  ram_sdp_clr_if #(.DATA_WIDTH(4), .ADDR_WIDTH(5)) if0 ();
  ram_sdp_clr_if #(.DATA_WIDTH(4), .ADDR_WIDTH(5)) if1 ();

  assign if0.clear_req = clear_req;
  assign if0.wr_en     = wr_en;
  assign if0.wr_addr   = wr_addr;
  assign if0.wr_data   = wr_data;
  assign if0.rd_en     = rd_en;
  assign if0.rd_addr   = rd_addr;
  assign if1.clear_req = clear_req;
  assign if1.wr_en     = wr_en;
  assign if1.wr_addr   = wr_addr;
  assign if1.wr_data   = wr_data;
  assign if1.rd_en     = rd_en;
  assign if1.rd_addr   = rd_addr;

  ram_sdp_clr #(.DATA_WIDTH(4), .ADDR_WIDTH(5), .RDW_MODE(0), .CLEAR_VALUE(4'h0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0));
  ram_sdp_clr #(.DATA_WIDTH(4), .ADDR_WIDTH(5), .RDW_MODE(1), .CLEAR_VALUE(4'h0)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1));

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Advance one clock; the model treats a clear as a countdown that wipes the array when done.
  task automatic cycle();
    if (busy_left > 0) begin
      busy_left--;
      exp_vld = 1'b0;
      if (busy_left == 0)
        for (int i = 0; i < 32; i++) mdl_mem[i] = 4'h0;
    end else begin
      exp_vld = rd_en;
      if (rd_en) begin
        exp_rd0 = mdl_mem[rd_addr];
        exp_rd1 = (wr_en && wr_addr == rd_addr) ? wr_data : mdl_mem[rd_addr];
      end
      if (wr_en) mdl_mem[wr_addr] = wr_data;
      if (clear_req) busy_left = 32;
    end
    exp_busy = (busy_left > 0);
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    busy_left = 32;
    exp_rd0   = 4'h0;
    exp_rd1   = 4'h0;
    exp_vld   = 1'b0;
    exp_busy  = 1'b1;
  endtask

  task automatic idle_inputs();
    clear_req = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({if0.busy, if1.busy, if0.rd_valid, if1.rd_valid, if0.rd_data, if1.rd_data} !== {2'b11, 2'b00, 8'h00}) begin
      $display("FAIL reset_state: busy=%b%b vld=%b%b data=%h/%h required busy=11 vld=00 data=0/0",
               if0.busy, if1.busy, if0.rd_valid, if1.rd_valid, if0.rd_data, if1.rd_data);
    end else n_pass++;
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      n++;
      if (!if0.busy) break;
    end
    n_checks++;
    if (n !== 32 || if1.busy !== 1'b0) begin
      $display("FAIL reset_busy_len: busy lasted %0d cycles (other inst busy=%b), required 32", n, if1.busy);
    end else n_pass++;
    for (int a = 0; a < 32; a++) begin
      rd_en = 1'b1;
      rd_addr = 5'(a);
      cycle();
      n_checks++;
      if (if0.rd_data !== 4'h0 || if1.rd_data !== 4'h0 || {if0.rd_valid, if1.rd_valid} !== 2'b11) begin
        $display("FAIL reset_read_%0d: data=%h/%h vld=%b%b required data=0 vld=11",
                 a, if0.rd_data, if1.rd_data, if0.rd_valid, if1.rd_valid);
      end else n_pass++;
    end
    idle_inputs();
    cycle();
    n_checks++;
    if ({if0.rd_valid, if1.rd_valid} !== 2'b00 || if0.rd_data !== exp_rd0) begin
      $display("FAIL no_read_vld: vld=%b%b data=%h required vld=00 data=%h",
               if0.rd_valid, if1.rd_valid, if0.rd_data, exp_rd0);
    end else n_pass++;
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 5'h0A; wr_data = 4'hA;
    cycle();
    wr_addr = 5'h02; wr_data = 4'h5;
    cycle();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = 5'h0A;
    cycle();
    n_checks++;
    if (if0.rd_data !== 4'hA || if1.rd_data !== 4'hA || if0.rd_valid !== 1'b1) begin
      $display("FAIL wr_rd_0A: data=%h/%h vld=%b required data=a vld=1", if0.rd_data, if1.rd_data, if0.rd_valid);
    end else n_pass++;
    rd_addr = 5'h02;
    cycle();
    n_checks++;
    if (if0.rd_data !== 4'h5 || if1.rd_data !== 4'h5 || if1.rd_valid !== 1'b1) begin
      $display("FAIL wr_rd_02: data=%h/%h vld=%b required data=5 vld=1", if0.rd_data, if1.rd_data, if1.rd_valid);
    end else n_pass++;
    idle_inputs();
  endtask

  task automatic test_rdw();
    wr_en = 1'b1; wr_addr = 5'h03; wr_data = 4'h1;
    cycle();
    wr_data = 4'h7;
    rd_en = 1'b1; rd_addr = 5'h03;
    cycle();
    n_checks++;
    if (if0.rd_data !== 4'h1) begin
      $display("FAIL rdw_read_old: got %h required 1", if0.rd_data);
    end else n_pass++;
    n_checks++;
    if (if1.rd_data !== 4'h7) begin
      $display("FAIL rdw_write_through: got %h required 7", if1.rd_data);
    end else n_pass++;
    wr_en = 1'b0;
    cycle();
    n_checks++;
    if (if0.rd_data !== 4'h7 || if1.rd_data !== 4'h7) begin
      $display("FAIL rdw_followup: got %h/%h required 7/7", if0.rd_data, if1.rd_data);
    end else n_pass++;
    idle_inputs();
  endtask

  task automatic test_clear();
    int n;
    logic [3:0] held0;
    held0 = if0.rd_data;
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      wr_en = (i == 2); wr_addr = 5'h04; wr_data = 4'hF;
      rd_en = (i >= 2 && i < 6); rd_addr = 5'h04;
      clear_req = (n == 20);
      cycle();
      n_checks++;
      if ({if0.rd_valid, if1.rd_valid} !== 2'b00 || if0.rd_data !== held0) begin
        $display("FAIL clear_rd_blocked_%0d: vld=%b%b data=%h required vld=00 data=%h",
                 i, if0.rd_valid, if1.rd_valid, if0.rd_data, held0);
      end else n_pass++;
      if (!if0.busy) break;
      n++;
    end
    idle_inputs();
    n_checks++;
    if (n !== 32 || if1.busy !== 1'b0) begin
      $display("FAIL clear_busy_len: busy lasted %0d cycles (other inst busy=%b), required 32", n, if1.busy);
    end else n_pass++;
    rd_en = 1'b1; rd_addr = 5'h04;
    cycle();
    n_checks++;
    if (if0.rd_data !== 4'h0 || if1.rd_data !== 4'h0 || if0.rd_valid !== 1'b1) begin
      $display("FAIL clear_rd_04: data=%h/%h vld=%b required data=0 vld=1", if0.rd_data, if1.rd_data, if0.rd_valid);
    end else n_pass++;
    rd_addr = 5'h0A;
    cycle();
    n_checks++;
    if (if0.rd_data !== 4'h0 || if1.rd_data !== 4'h0) begin
      $display("FAIL clear_rd_0A: data=%h/%h required 0", if0.rd_data, if1.rd_data);
    end else n_pass++;
    idle_inputs();
  endtask

  task automatic test_reset_midclear();
    int n;
    wr_en = 1'b1; wr_addr = 5'h03; wr_data = 4'h9;
    cycle();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 5'h03;
    cycle();
    rd_en = 1'b0;
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    repeat (9) cycle();
    n_checks++;
    if (if0.rd_data !== 4'h9 || if0.busy !== 1'b1) begin
      $display("FAIL midclear_pre: data=%h busy=%b required data=9 busy=1", if0.rd_data, if0.busy);
    end else n_pass++;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({if0.rd_data, if1.rd_data} !== 8'h00 || {if0.rd_valid, if1.rd_valid} !== 2'b00) begin
      $display("FAIL midclear_async_reset: data=%h/%h vld=%b%b required 0/0 00",
               if0.rd_data, if1.rd_data, if0.rd_valid, if1.rd_valid);
    end else n_pass++;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      n++;
      if (!if0.busy) break;
    end
    n_checks++;
    if (n !== 32 || if1.busy !== 1'b0) begin
      $display("FAIL midclear_restart_len: busy lasted %0d cycles, required 32", n);
    end else n_pass++;
    rd_en = 1'b1; rd_addr = 5'h03;
    cycle();
    n_checks++;
    if (if0.rd_data !== 4'h0 || if1.rd_data !== 4'h0) begin
      $display("FAIL midclear_rd_03: data=%h/%h required 0", if0.rd_data, if1.rd_data);
    end else n_pass++;
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = 5'($urandom_range(0, 31));
      wr_data   = 4'($urandom_range(0, 15));
      rd_en     = ($urandom_range(0, 3) != 0);
      rd_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      clear_req = ($urandom_range(0, 99) == 0);
      cycle();
      n_checks++;
      if ({if0.busy, if1.busy} !== {2{exp_busy}} || {if0.rd_valid, if1.rd_valid} !== {2{exp_vld}}) begin
        $display("FAIL rand_ctrl_%0d: busy=%b%b vld=%b%b required busy=%b vld=%b",
                 i, if0.busy, if1.busy, if0.rd_valid, if1.rd_valid, exp_busy, exp_vld);
      end else n_pass++;
      n_checks++;
      if (if0.rd_data !== exp_rd0 || if1.rd_data !== exp_rd1) begin
        $display("FAIL rand_data_%0d: data=%h/%h required %h/%h", i, if0.rd_data, if1.rd_data, exp_rd0, exp_rd1);
      end else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl_mem[i] = 4'h0;
    test_reset();
    test_write_read();
    test_rdw();
    test_clear();
    test_reset_midclear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_sdp_clr.md
# ram_sdp_clr

Parametrised simple-dual-port synchronous RAM with a hardware clear sequencer; the next generation of the team's small single-port RAMs. Provides one write port and one read port per clock, configurable width, depth and read-during-write behaviour. A built-in state machine clears the array one word per cycle, so the array maps onto block RAM instead of flip-flops. Used as the general scratch/buffer memory in lab datapaths.

## Interface
- DATA_WIDTH, 4, bits per word
- ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH (derived, not overridable)
- RDW_MODE, 0, same-address read-during-write: 0 = read-old, 1 = write-through
- CLEAR_VALUE, '0, word written to every address by the clear sequence
- clk  in  1  clock, rising edge
- reset_n  in  1  reset; asynchronous, active-low
- clear_req  in  1  start a full-array clear (sampled in IDLE only)
- busy  out  1  high while a clear is in progress
- wr_en  in  1  write enable
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  read enable
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  DATA_WIDTH  registered read data
- rd_valid  out  1  one-cycle strobe: rd_data updated this cycle

## Operation
- FSM states: IDLE, CLEAR. reset_n low: state = CLEAR, clr_addr = 0, rd_data = 0, rd_valid = 0; busy = 1 (busy decodes state == CLEAR). Array contents are not reset.
- CLEAR: each cycle write CLEAR_VALUE to clr_addr, clr_addr++. At clr_addr == DEPTH-1 the write is made and state -> IDLE next edge; clr_addr wraps to 0.
- After reset release, busy stays high exactly DEPTH cycles.
- IDLE + clear_req -> CLEAR next edge. clear_req during CLEAR is ignored; it neither restarts nor extends the clear.
- While busy: wr_en dropped (no array write), rd_en dropped (rd_valid stays 0, rd_data holds).
- IDLE write: wr_en high -> memory[wr_addr] = wr_data at the edge.
- IDLE read: rd_en high -> rd_data = memory[rd_addr], rd_valid = 1 after the edge. Without rd_en: rd_valid = 0, rd_data holds its last value.
- Same-address write + read in one cycle: RDW_MODE 0 returns the pre-write word; RDW_MODE 1 returns wr_data. The write always lands.
- Different-address simultaneous read and write: independent, both complete.
- reset_n asserted mid-clear: the sequence aborts and restarts from address 0 on release.

## Timing
- Read latency 1 cycle: rd_en at edge N -> rd_data/rd_valid valid from edge N until edge N+1.
- Write visible to a read issued the following cycle.
- Back-to-back reads: one result per cycle, rd_valid high continuously.
- busy: 0 -> 1 on the edge that samples clear_req; 1 -> 0 on the edge after the DEPTH-1 clear write.
- Outputs change only on the clk edge, or asynchronously on reset_n falling.

## Structure
- Package ram_pkg holds:
  - typedef enum ram_state_e {RAM_IDLE, RAM_CLEAR}
  - constants RDW_READ_OLD = 0 and RDW_WRITE_THROUGH = 1
- Sub-module ram_clear_fsm owns state, clr_addr and busy, and outputs the muxed write strobe/address/data.
- Top level holds the array and the read register.

## Test plan (DATA_WIDTH = 4, ADDR_WIDTH = 5)
- Release reset_n -> busy high exactly 32 cycles, then low; reading addresses 0..31 returns 4'h0 with rd_valid one cycle after each rd_en.
- Write 4'hA @ 5'h0A, then 4'h5 @ 5'h02; read 5'h0A, then 5'h02 -> rd_data 4'hA, then 4'h5, each one cycle after rd_en.
- Address 5'h03 holds 4'h1; write 4'h7 and read 5'h03 in the same cycle -> RDW_MODE 0 returns 4'h1, RDW_MODE 1 returns 4'h7; a following read returns 4'h7 in both modes.
- Pulse clear_req in IDLE with data loaded; during the clear, write 4'hF @ 5'h04 and issue a read -> busy 32 cycles, rd_valid stays 0; afterwards 5'h04 and 5'h0A read 4'h0.
- Pulse clear_req again at clear cycle 20 -> busy still falls after 32 total cycles.
- Assert reset_n low at clear cycle 10 -> rd_data = 0 and rd_valid = 0 immediately; on release the clear restarts from 0 and busy lasts a full 32 cycles.
